// File: rtl/cpu.sv
// Multi-cycle RV32I core: Fetch -> Inst -> Exec (-> Load) over one word-addressed bus.
// One instruction in flight; no caches, interrupts or CSRs.
module cpu (
    input  logic        clock,
    input  logic        reset,
    output logic [29:0] bus_addr,
    input  logic [31:0] bus_data_r,
    output logic [31:0] bus_data_w,
    output logic [3:0]  bus_mask_w
);

    localparam int StFetch = 0;
    localparam int StInst  = 1;
    localparam int StExec  = 2;
    localparam int StLoad  = 3;

    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpImm    = 7'h13;
    localparam logic [6:0] OpAuipc  = 7'h17;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpOp     = 7'h33;
    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpJal    = 7'h6f;

    logic [3:0]  state, state_d;
    logic [29:0] pc, pc_d;
    logic [31:0] inst, inst_d;
    logic [1:0]  loadOff_q, loadOff_d;
    logic [2:0]  loadF3_q, loadF3_d;
    logic [31:0] regs [0:31];

    logic [6:0]  opcode;
    logic [4:0]  rdIdx, rs1Idx, rs2Idx;
    logic [2:0]  f3;
    logic [31:0] immI, immS, immB, immU, immJ;
    logic [31:0] rs1v, rs2v, opB, aluOut, memEa, pcByte, loadVal;
    logic [4:0]  shAmt;
    logic        taken, regWe;
    logic [31:0] regWd;

    assign opcode = inst[6:0];
    assign rdIdx  = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1Idx = inst[19:15];
    assign rs2Idx = inst[24:20];
    assign immI   = {{20{inst[31]}}, inst[31:20]};
    assign immS   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign immB   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign immU   = {inst[31:12], 12'b0};
    assign immJ   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    assign rs1v   = (rs1Idx == 5'd0) ? 32'd0 : regs[rs1Idx];
    assign rs2v   = (rs2Idx == 5'd0) ? 32'd0 : regs[rs2Idx];
    assign pcByte = {pc, 2'b00};
    assign opB    = (opcode == OpOp) ? rs2v : immI;
    assign shAmt  = opB[4:0];
    assign memEa  = rs1v + ((opcode == OpStore) ? immS : immI);

    always_comb begin
        aluOut = 32'd0;
        case (f3)
            3'd0: aluOut = (opcode == OpOp && inst[30]) ? rs1v - opB : rs1v + opB;
            3'd1: aluOut = rs1v << shAmt;
            3'd2: aluOut = {31'd0, $signed(rs1v) < $signed(opB)};
            3'd3: aluOut = {31'd0, rs1v < opB};
            3'd4: aluOut = rs1v ^ opB;
            3'd5: aluOut = inst[30] ? 32'($signed(rs1v) >>> shAmt) : rs1v >> shAmt;
            3'd6: aluOut = rs1v | opB;
            default: aluOut = rs1v & opB;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (f3)
            3'd0: taken = (rs1v == rs2v);
            3'd1: taken = (rs1v != rs2v);
            3'd4: taken = ($signed(rs1v) < $signed(rs2v));
            3'd5: taken = ($signed(rs1v) >= $signed(rs2v));
            3'd6: taken = (rs1v < rs2v);
            3'd7: taken = (rs1v >= rs2v);
            default: taken = 1'b0;
        endcase
    end

    // Lane selection uses the offset latched in StExec, since bus_data_r arrives one cycle later.
    always_comb begin
        logic [7:0]  byteSel;
        logic [15:0] halfSel;
        case (loadOff_q)
            2'd0: byteSel = bus_data_r[7:0];
            2'd1: byteSel = bus_data_r[15:8];
            2'd2: byteSel = bus_data_r[23:16];
            default: byteSel = bus_data_r[31:24];
        endcase
        halfSel = loadOff_q[1] ? bus_data_r[31:16] : bus_data_r[15:0];
        case (loadF3_q)
            3'd0: loadVal = {{24{byteSel[7]}}, byteSel};
            3'd1: loadVal = {{16{halfSel[15]}}, halfSel};
            3'd4: loadVal = {24'd0, byteSel};
            3'd5: loadVal = {16'd0, halfSel};
            default: loadVal = bus_data_r;
        endcase
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        inst_d     = inst;
        loadOff_d  = loadOff_q;
        loadF3_d   = loadF3_q;
        regWe      = 1'b0;
        regWd      = 32'd0;
        bus_addr   = pc;
        bus_data_w = rs2v;
        bus_mask_w = 4'b0000;
        if (state[StFetch]) begin
            state_d = 4'b0010;
        end else if (state[StInst]) begin
            inst_d  = bus_data_r;
            state_d = 4'b0100;
        end else if (state[StExec]) begin
            pc_d    = pc + 30'd1;
            state_d = 4'b0001;
            case (opcode)
                OpOp, OpImm: begin
                    regWe = 1'b1;
                    regWd = aluOut;
                end
                OpLui: begin
                    regWe = 1'b1;
                    regWd = immU;
                end
                OpAuipc: begin
                    regWe = 1'b1;
                    regWd = pcByte + immU;
                end
                OpJal: begin
                    regWe = 1'b1;
                    regWd = pcByte + 32'd4;
                    pc_d  = 30'((pcByte + immJ) >> 2);
                end
                OpJalr: begin
                    regWe = 1'b1;
                    regWd = pcByte + 32'd4;
                    pc_d  = 30'((rs1v + immI) >> 2);
                end
                OpBranch: begin
                    if (taken) pc_d = 30'((pcByte + immB) >> 2);
                end
                OpLoad: begin
                    bus_addr  = 30'(memEa >> 2);
                    loadOff_d = memEa[1:0];
                    loadF3_d  = f3;
                    pc_d      = pc;
                    state_d   = 4'b1000;
                end
                OpStore: begin
                    bus_addr = 30'(memEa >> 2);
                    case (f3)
                        3'd0: begin
                            bus_data_w = {4{rs2v[7:0]}};
                            bus_mask_w = 4'b0001 << memEa[1:0];
                        end
                        3'd1: begin
                            bus_data_w = {2{rs2v[15:0]}};
                            bus_mask_w = 4'b0011 << {memEa[1], 1'b0};
                        end
                        3'd2: begin
                            bus_data_w = rs2v;
                            bus_mask_w = 4'b1111;
                        end
                        default: bus_mask_w = 4'b0000;
                    endcase
                end
                default: ;
            endcase
        end else if (state[StLoad]) begin
            regWe   = 1'b1;
            regWd   = loadVal;
            pc_d    = pc + 30'd1;
            state_d = 4'b0001;
        end else begin
            state_d = 4'b0001;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= 4'b0001;
            pc        <= 30'd0;
            inst      <= 32'd0;
            loadOff_q <= 2'd0;
            loadF3_q  <= 3'd0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            inst      <= inst_d;
            loadOff_q <= loadOff_d;
            loadF3_q  <= loadF3_d;
        end
    end

    // Register file is not reset; x0 is never written and always reads as zero.
    always_ff @(posedge clock) begin
        if (regWe && rdIdx != 5'd0) regs[rdIdx] <= regWd;
    end

endmodule

// File: tb/tb_cpu.sv
// Directed programs for cpu against a one-cycle-latency byte-write RAM model.
module tb_cpu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] busAddr;
    logic [31:0] busDataR;
    logic [31:0] busDataW;
    logic [3:0]  busMaskW;

    logic [31:0] mem [0:255];
    logic        progWe = 1'b0;
    logic [7:0]  progAddr = 8'd0;
    logic [31:0] progData = 32'd0;

    int checkCount = 0;
    int errorCount = 0;

    cpu dut (
        .clock      (clock),
        .reset      (reset),
        .bus_addr   (busAddr),
        .bus_data_r (busDataR),
        .bus_data_w (busDataW),
        .bus_mask_w (busMaskW)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (progWe) begin
            mem[progAddr] <= progData;
        end else begin
            for (int b = 0; b < 4; b++)
                if (busMaskW[b]) mem[busAddr[7:0]][b*8 +: 8] <= busDataW[b*8 +: 8];
        end
        busDataR <= mem[busAddr[7:0]];
    end

    function automatic logic [31:0] encI(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                         logic [4:0] rd, logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encR(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] encS(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] encB(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] encJ(logic [31:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pokeWord(input logic [7:0] addr, input logic [31:0] data);
        progAddr = addr;
        progData = data;
        progWe   = 1'b1;
        @(posedge clock);
        #1;
        progWe = 1'b0;
    endtask

    // Holds the core in reset while memory is cleared and the program is written.
    task automatic loadProgram(input logic [31:0] prog [$]);
        reset = 1'b1;
        for (int a = 0; a < 256; a++) pokeWord(8'(a), 32'd0);
        foreach (prog[i]) pokeWord(8'(i), prog[i]);
    endtask

    task automatic releaseReset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] prog [$];

        // addi x10,x0,5; addi x10,x10,-5; ecall
        prog = '{encI(32'd5, 5'd0, 3'd0, 5'd10, 7'h13),
                 encI(32'hFFFFFFFB, 5'd10, 3'd0, 5'd10, 7'h13),
                 32'h00000073};
        loadProgram(prog);
        checkOutput("reset_state", {28'd0, dut.state}, 32'h1);
        checkOutput("reset_pc", {2'b0, dut.pc}, 32'd0);
        checkOutput("reset_inst", dut.inst, 32'd0);
        checkOutput("reset_mask", {28'd0, busMaskW}, 32'd0);
        releaseReset();
        applyStimulus(8);
        checkOutput("ecall_state", {28'd0, dut.state}, 32'h4);
        checkOutput("ecall_inst", dut.inst, 32'h00000073);
        checkOutput("ecall_pc", {2'b0, dut.pc}, 32'd2);
        checkOutput("ecall_x10", dut.regs[10], 32'd0);
        applyStimulus(1);
        checkOutput("ecall_one_cycle", {28'd0, dut.state}, 32'h1);
        checkOutput("ecall_pc_next", {2'b0, dut.pc}, 32'd3);

        // lui/addi/sw/lb/lhu round trip through word 0x40
        prog = '{{20'h12345, 5'd1, 7'h37},
                 encI(32'h678, 5'd1, 3'd0, 5'd1, 7'h13),
                 encS(32'h100, 5'd1, 5'd0, 3'd2),
                 encI(32'h101, 5'd0, 3'd0, 5'd2, 7'h03),
                 encI(32'h102, 5'd0, 3'd5, 5'd3, 7'h03)};
        loadProgram(prog);
        releaseReset();
        applyStimulus(17);
        checkOutput("sw_word", mem[8'h40], 32'h12345678);
        checkOutput("lb_x2", dut.regs[2], 32'h00000056);
        checkOutput("lhu_x3", dut.regs[3], 32'h00001234);
        checkOutput("load_pc", {2'b0, dut.pc}, 32'd5);

        // sb into the top lane, then sign-extending lb
        prog = '{encI(32'hFFFFFFFF, 5'd0, 3'd0, 5'd1, 7'h13),
                 encS(32'h203, 5'd1, 5'd0, 3'd0),
                 encI(32'h203, 5'd0, 3'd0, 5'd4, 7'h03)};
        loadProgram(prog);
        releaseReset();
        applyStimulus(5);
        checkOutput("sb_mask", {28'd0, busMaskW}, 32'h8);
        checkOutput("sb_addr", {2'b0, busAddr}, 32'h80);
        applyStimulus(1);
        checkOutput("sb_mask_drop", {28'd0, busMaskW}, 32'h0);
        applyStimulus(4);
        checkOutput("sb_word", mem[8'h80], 32'hFF000000);
        checkOutput("lb_x4", dut.regs[4], 32'hFFFFFFFF);

        // countdown loop: addi x1,x0,3; addi x1,x1,-1; bne x1,x0,-4
        prog = '{encI(32'd3, 5'd0, 3'd0, 5'd1, 7'h13),
                 encI(32'hFFFFFFFF, 5'd1, 3'd0, 5'd1, 7'h13),
                 encB(32'hFFFFFFFC, 5'd0, 5'd1, 3'd1)};
        loadProgram(prog);
        releaseReset();
        applyStimulus(9);
        checkOutput("loop_taken_pc", {2'b0, dut.pc}, 32'd1);
        checkOutput("loop_x1_mid", dut.regs[1], 32'd2);
        applyStimulus(12);
        checkOutput("loop_exit_pc", {2'b0, dut.pc}, 32'd3);
        checkOutput("loop_x1", dut.regs[1], 32'd0);

        // jal x1,+8 at byte 0x10; jalr x0,0(x1) at byte 0x18
        prog = '{32'd0, 32'd0, 32'd0, 32'd0,
                 encJ(32'd8, 5'd1),
                 32'd0,
                 encI(32'd0, 5'd1, 3'd0, 5'd0, 7'h67)};
        loadProgram(prog);
        releaseReset();
        applyStimulus(15);
        checkOutput("jal_pc", {2'b0, dut.pc}, 32'h6);
        checkOutput("jal_x1", dut.regs[1], 32'h14);
        applyStimulus(3);
        checkOutput("jalr_pc", {2'b0, dut.pc}, 32'h5);

        // shifts, compares, sub, and x0 write dropping
        prog = '{{20'h80000, 5'd1, 7'h37},
                 encI(32'd31, 5'd0, 3'd0, 5'd2, 7'h13),
                 encR(7'h20, 5'd2, 5'd1, 3'd5, 5'd3),
                 encR(7'h00, 5'd2, 5'd1, 3'd5, 5'd4),
                 encI(32'hFFFFFFFF, 5'd0, 3'd0, 5'd5, 7'h13),
                 encI(32'd1, 5'd0, 3'd0, 5'd6, 7'h13),
                 encR(7'h00, 5'd6, 5'd5, 3'd2, 5'd7),
                 encR(7'h00, 5'd6, 5'd5, 3'd3, 5'd8),
                 encI(32'd1, 5'd0, 3'd0, 5'd0, 7'h13),
                 encR(7'h00, 5'd0, 5'd0, 3'd0, 5'd9),
                 encR(7'h20, 5'd5, 5'd6, 3'd0, 5'd10)};
        loadProgram(prog);
        releaseReset();
        applyStimulus(33);
        checkOutput("sra_x3", dut.regs[3], 32'hFFFFFFFF);
        checkOutput("srl_x4", dut.regs[4], 32'h00000001);
        checkOutput("slt_x7", dut.regs[7], 32'd1);
        checkOutput("sltu_x8", dut.regs[8], 32'd0);
        checkOutput("x0_reads_zero", dut.regs[9], 32'd0);
        checkOutput("sub_x10", dut.regs[10], 32'd2);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cpu.md
# cpu

Multi-cycle RV32I integer core: fetches, decodes and executes one instruction at a time over a single 32-bit word-addressed memory bus. It is the only bus master in the system and connects directly to a synchronous single-port RAM with one-cycle read latency and per-byte write enables. There are no caches, no interrupts and no CSRs; ECALL, EBREAK and FENCE retire as no-ops.

## Interface
- One clock; reset is asynchronous and active-high.
- No parameters. State indices are localparams `StFetch`, `StInst`, `StExec`, `StLoad` (0..3).
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- bus_addr  out  30  word address (byte address >> 2); combinational from state
- bus_data_r  in  32  read data; valid the cycle after an address is driven with mask 0
- bus_data_w  out  32  write data, byte lanes already shifted into position
- bus_mask_w  out  4  byte write enables; 0 means a read
- Internal signals readable by hierarchy, with fixed names:
  - `state[3:0]`: one-hot state vector.
  - `inst[31:0]`: current instruction.
  - `pc[29:0]`: word PC.
  - `regs[0:31][31:0]`: register file.

## Operation
- Reset:
  - state = StFetch, pc = 0, inst = 0.
  - regs are not reset. x0 always reads 0, and writes to it are dropped.
- StFetch:
  - bus_addr = pc, mask 0.
  - Next state is StInst.
- StInst:
  - inst <= bus_data_r.
  - Next state is StExec.
- StExec: decode `inst`, read rs1/rs2, execute:
  - OP / OP-IMM: all RV32I ALU ops. Shifts use the low 5 bits; SRA/SRAI are arithmetic; SLT/SLTU are signed/unsigned compares. Write rd, pc <= pc+1, go to StFetch.
  - LUI: rd = imm<<12. AUIPC: rd = 4*pc + (imm<<12).
  - JAL: rd = 4*pc+4; pc <= (4*pc + J-imm)[31:2].
  - JALR: target = (rs1 + I-imm) & ~1; pc <= target[31:2].
  - Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU): if taken, pc <= (4*pc + B-imm)[31:2]; else pc+1.
  - Loads: ea = rs1 + I-imm. Drive bus_addr = ea[31:2], mask 0, and go to StLoad. Latch ea[1:0] and funct3.
  - Stores: ea = rs1 + S-imm; bus_addr = ea[31:2].
    - SB: data = {4{rs2[7:0]}}, mask = 0001<<ea[1:0].
    - SH: data = {2{rs2[15:0]}}, mask = 0011<<{ea[1],0}.
    - SW: data = rs2, mask = 1111.
    - pc+1, go to StFetch.
  - SYSTEM, MISC-MEM and any unrecognised opcode: pc+1, no other effect.
- StLoad:
  - Select byte/halfword from bus_data_r using ea[1:0] (ea[1] for halfwords).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the whole word.
  - Write rd, pc <= pc+1, go to StFetch.
- Misaligned accesses use the truncated lane offset and never cross a word boundary. Jump and branch targets drop byte-address bits [1:0]; no exception is raised.
- bus_mask_w is nonzero only in StExec for stores; it is 0 in every other state.
- bus_data_w is don't-care when the mask is 0.
- Arithmetic is 32-bit modulo 2^32; pc wraps modulo 2^30.

## Timing
- ALU, jump, branch, store and system instructions take 3 cycles (Fetch, Inst, Exec).
- Loads take 4 cycles (Fetch, Inst, Exec, Load).
- The store write commits on the clock edge that ends StExec.
- Register writes and pc updates occur on the edge that leaves StExec (or StLoad for loads).
- A read issued in cycle N yields bus_data_r in cycle N+1. The core never issues back-to-back reads without a consuming state in between.
- Reset asserted mid-instruction aborts it immediately: state returns to StFetch and pc to 0. A store is suppressed unless the edge ending StExec has already occurred.
- While in StExec with inst == 0x00000073 (ECALL), the core is observably in StExec for exactly one cycle.

## Test plan
- Reset, then program `addi x10,x0,5; addi x10,x10,-5; ecall` → the ECALL is reached in StExec with x10 = 0, and pc = 2 there.
- `lui x1,0x12345; addi x1,x1,0x678; sw x1,0x100(x0); lb x2,0x101(x0); lhu x3,0x102(x0)` → mem word 0x40 = 0x12345678; x2 = 0x00000056; x3 = 0x00001234.
- `addi x1,x0,-1; sb x1,0x203(x0)` over a word preset to 0 → word = 0xFF000000 with mask 1000 asserted for a single cycle; `lb` at 0x203 returns 0xFFFFFFFF.
- Branch loop: `addi x1,x0,3; loop: addi x1,x1,-1; bne x1,x0,loop` → exits with x1 = 0 after 3 iterations, taking 3 cycles per non-memory instruction.
- `jal x1,+8` at byte 0x10 → pc = 0x18/4 and x1 = 0x14. `jalr x0,0(x1)` → return to 0x14.
- `sra`/`srl` of 0x80000000 by 31 → 0xFFFFFFFF and 0x00000001. `slt`/`sltu` of -1 vs 1 → 1 and 0. `addi x0,x0,1` → x0 still reads 0.
